// File: rtl/lcd_fb_pkg.sv
// Shared types and constants for the LCD/camera frame-buffer arbiter.
package lcd_fb_pkg;

  localparam int unsigned FRAME_WORDS_VGA = 32'd640 * 32'd480;
  localparam int unsigned BURST_DEFAULT   = 32'd64;

  localparam logic CMD_WE_WRITE = 1'b1;
  localparam logic CMD_WE_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAM_CMD  = 3'd1,
    ST_CAM_XFER = 3'd2,
    ST_LCD_CMD  = 3'd3,
    ST_LCD_XFER = 3'd4
  } arb_state_e;

  // Saturating increment used by the LCD run counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] max);
    logic [7:0] res;
    if (val >= max) begin
      res = max;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Per-requester frame offset: +BURST on command accept, wrap at frame end,
// and deferred restart to offset 0 on a frame-start pulse.
module fb_addr_gen
  import lcd_fb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned BURST       = BURST_DEFAULT,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_VGA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy_i,
  input  logic              advance_i,
  input  logic              frame_start_i,
  output logic [ADDR_W-1:0] offset_o
);

  localparam logic [ADDR_W:0] BURST_W = (ADDR_W+1)'(BURST);
  localparam logic [ADDR_W:0] FRAME_W = (ADDR_W+1)'(FRAME_WORDS);

  logic [ADDR_W-1:0] offset_q, offset_d;
  logic              pending_q, pending_d;
  logic              restart_now_s;
  logic [ADDR_W:0]   sum_s;

  // Next offset and pending-restart flag.
  always_comb begin
    restart_now_s = (pending_q || frame_start_i) && !busy_i;
    sum_s         = {1'b0, offset_q} + BURST_W;
    offset_d      = offset_q;
    pending_d     = pending_q;
    if (advance_i && frame_start_i) begin
      // A restart landing on the accept cycle wins over the advance.
      offset_d  = '0;
      pending_d = 1'b0;
    end else if (advance_i) begin
      offset_d = (sum_s >= FRAME_W) ? '0 : sum_s[ADDR_W-1:0];
    end else if (restart_now_s) begin
      offset_d  = '0;
      pending_d = 1'b0;
    end else if (frame_start_i) begin
      pending_d = 1'b1;
    end else begin
      offset_d  = offset_q;
      pending_d = pending_q;
    end
  end

  // Offset and pending-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      offset_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      offset_q  <= offset_d;
      pending_q <= pending_d;
    end
  end

  // An idle requester sees a pending restart immediately, so a command
  // issued in the same cycle already starts at the frame base.
  assign offset_o = restart_now_s ? '0 : offset_q;

endmodule

// File: rtl/lcd_fb_arbiter.sv
// Shares one SDRAM burst-command port between camera writes and LCD
// prefetch reads; LCD has priority, bounded by a camera starvation guard.
module lcd_fb_arbiter
  import lcd_fb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned BURST       = BURST_DEFAULT,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_VGA,
  parameter int unsigned FB_BASE     = 0,
  parameter int unsigned MAX_LCD_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_req,
  input  logic              cam_frame_start,
  input  logic              lcd_req,
  input  logic              lcd_frame_start,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_burst_done,
  output logic              cam_grant,
  output logic              lcd_grant
);

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(FB_BASE);
  localparam logic [7:0]        RUN_MAX = 8'(MAX_LCD_RUN);

  arb_state_e        state_q;
  logic [7:0]        run_q;
  logic              valid_q, we_q, cam_grant_q, lcd_grant_q;
  logic [ADDR_W-1:0] addr_q;

  logic              cam_busy_s, lcd_busy_s;
  logic              cam_accept_s, lcd_accept_s;
  logic              lcd_wins_s;
  logic [ADDR_W-1:0] cam_off_s, lcd_off_s;

  assign cam_busy_s   = (state_q == ST_CAM_CMD) || (state_q == ST_CAM_XFER);
  assign lcd_busy_s   = (state_q == ST_LCD_CMD) || (state_q == ST_LCD_XFER);
  assign cam_accept_s = (state_q == ST_CAM_CMD) && mem_cmd_ready;
  assign lcd_accept_s = (state_q == ST_LCD_CMD) && mem_cmd_ready;
  assign lcd_wins_s   = lcd_req && !(cam_req && (run_q == RUN_MAX));

  fb_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BURST       (BURST),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_cam_addr (
    .clk           (clk),
    .reset         (reset),
    .busy_i        (cam_busy_s),
    .advance_i     (cam_accept_s),
    .frame_start_i (cam_frame_start),
    .offset_o      (cam_off_s)
  );

  fb_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BURST       (BURST),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_lcd_addr (
    .clk           (clk),
    .reset         (reset),
    .busy_i        (lcd_busy_s),
    .advance_i     (lcd_accept_s),
    .frame_start_i (lcd_frame_start),
    .offset_o      (lcd_off_s)
  );

  // Arbitration FSM with registered command and grant outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      run_q       <= 8'd0;
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      cam_grant_q <= 1'b0;
      lcd_grant_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lcd_wins_s) begin
            state_q <= ST_LCD_CMD;
            valid_q <= 1'b1;
            we_q    <= CMD_WE_READ;
            addr_q  <= BASE_A + lcd_off_s;
          end else if (cam_req) begin
            state_q <= ST_CAM_CMD;
            valid_q <= 1'b1;
            we_q    <= CMD_WE_WRITE;
            addr_q  <= BASE_A + cam_off_s;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CAM_CMD: begin
          if (mem_cmd_ready) begin
            state_q     <= ST_CAM_XFER;
            valid_q     <= 1'b0;
            cam_grant_q <= 1'b1;
            run_q       <= 8'd0;
          end else begin
            state_q <= ST_CAM_CMD;
          end
        end
        ST_CAM_XFER: begin
          if (mem_burst_done) begin
            state_q     <= ST_IDLE;
            cam_grant_q <= 1'b0;
          end else begin
            state_q <= ST_CAM_XFER;
          end
        end
        ST_LCD_CMD: begin
          if (mem_cmd_ready) begin
            state_q     <= ST_LCD_XFER;
            valid_q     <= 1'b0;
            lcd_grant_q <= 1'b1;
            // Only LCD bursts that actually hold off the camera count.
            run_q       <= cam_req ? sat_inc(run_q, RUN_MAX) : 8'd0;
          end else begin
            state_q <= ST_LCD_CMD;
          end
        end
        ST_LCD_XFER: begin
          if (mem_burst_done) begin
            state_q     <= ST_IDLE;
            lcd_grant_q <= 1'b0;
          end else begin
            state_q <= ST_LCD_XFER;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          valid_q     <= 1'b0;
          cam_grant_q <= 1'b0;
          lcd_grant_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_cmd_valid = valid_q;
  assign mem_cmd_we    = we_q;
  assign mem_cmd_addr  = addr_q;
  assign cam_grant     = cam_grant_q;
  assign lcd_grant     = lcd_grant_q;

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all outputs
// compared every cycle against a transaction-level reference model.
module tb_lcd_fb_arbiter;

  localparam int AW   = 19;
  localparam int BL   = 64;
  localparam int FW   = 307200;
  localparam int BASE = 0;
  localparam int MAXR = 4;

  logic          clk = 1'b0;
  logic          reset, cam_req, cam_frame_start, lcd_req, lcd_frame_start;
  logic          mem_cmd_ready, mem_burst_done;
  logic          mem_cmd_valid, mem_cmd_we, cam_grant, lcd_grant;
  logic [AW-1:0] mem_cmd_addr;

  always #5 clk = ~clk;

  lcd_fb_arbiter #(
    .ADDR_W(AW), .BURST(BL), .FRAME_WORDS(FW), .FB_BASE(BASE), .MAX_LCD_RUN(MAXR)
  ) dut (
    .clk(clk), .reset(reset),
    .cam_req(cam_req), .cam_frame_start(cam_frame_start),
    .lcd_req(lcd_req), .lcd_frame_start(lcd_frame_start),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_burst_done(mem_burst_done),
    .cam_grant(cam_grant), .lcd_grant(lcd_grant)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 cam, 2 lcd), whether the
  // command was taken, per-requester offsets/pending restarts, LCD run length.
  int m_kind, m_xcnt, m_xlen, m_run;
  bit m_xfer;
  int m_off[3];
  bit m_pend[3];
  bit e_valid, e_we, e_cg, e_lg;
  int e_addr;
  int xfer_len_cfg = 2;
  bit rand_len = 1'b0;

  task automatic model_step();
    bit fs[3];
    bit acc;
    if (reset) begin
      m_kind = 0; m_xfer = 0; m_run = 0; m_xcnt = 0; m_xlen = 0;
      for (int r = 0; r < 3; r++) begin m_off[r] = 0; m_pend[r] = 0; end
      e_valid = 0; e_we = 0; e_cg = 0; e_lg = 0; e_addr = 0;
      return;
    end
    fs[0] = 0; fs[1] = cam_frame_start; fs[2] = lcd_frame_start;
    acc = (m_kind != 0) && !m_xfer && mem_cmd_ready;
    for (int r = 1; r <= 2; r++) begin
      if (m_kind == r && acc) begin
        if (fs[r]) begin m_off[r] = 0; m_pend[r] = 0; end
        else m_off[r] = (m_off[r] + BL) % FW;
      end else if (m_kind == r) begin
        if (fs[r]) m_pend[r] = 1;
      end else if (fs[r] || m_pend[r]) begin
        m_off[r] = 0; m_pend[r] = 0;
      end
    end
    if (m_kind == 0) begin
      if (lcd_req && !(cam_req && m_run == MAXR)) begin
        m_kind = 2; m_xfer = 0; e_valid = 1; e_we = 0; e_addr = BASE + m_off[2];
      end else if (cam_req) begin
        m_kind = 1; m_xfer = 0; e_valid = 1; e_we = 1; e_addr = BASE + m_off[1];
      end
    end else if (!m_xfer) begin
      if (acc) begin
        if (m_kind == 2) m_run = cam_req ? ((m_run < MAXR) ? m_run + 1 : MAXR) : 0;
        else m_run = 0;
        m_xfer = 1; e_valid = 0; e_cg = (m_kind == 1); e_lg = (m_kind == 2);
        m_xcnt = 0;
        m_xlen = rand_len ? int'($urandom_range(0, xfer_len_cfg)) : xfer_len_cfg;
      end
    end else if (mem_burst_done) begin
      m_kind = 0; m_xfer = 0; e_cg = 0; e_lg = 0;
    end else begin
      m_xcnt++;
    end
  endtask

  task automatic cycle();
    mem_burst_done = (m_kind != 0) && m_xfer && (m_xcnt >= m_xlen);
    model_step();
    @(posedge clk);
    #1;
    chk("valid", mem_cmd_valid, e_valid);
    chk("cam_grant", cam_grant, e_cg);
    chk("lcd_grant", lcd_grant, e_lg);
    if (e_valid) begin
      chk("we", mem_cmd_we, e_we);
      chk("addr", mem_cmd_addr, e_addr);
    end
  endtask

  task automatic wait_cmd(input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      cycle();
      if (mem_cmd_valid === 1'b1) found = 1;
    end
    if (!found) chk("cmd_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_we;
    logic [9:0] got_we;
    int cam_addr[$];
    reset = 1'b1; cam_req = 1'b0; lcd_req = 1'b0; cam_frame_start = 1'b0;
    lcd_frame_start = 1'b0; mem_cmd_ready = 1'b0; mem_burst_done = 1'b0;
    #2;
    do_reset();
    chk("reset_valid", mem_cmd_valid, 32'd0);

    // Single LCD requester: first command one cycle after the request.
    mem_cmd_ready = 1'b1; lcd_req = 1'b1; xfer_len_cfg = 2;
    cycle();
    chk("first_valid", mem_cmd_valid, 32'd1);
    chk("first_we", mem_cmd_we, 32'd0);
    chk("first_addr", mem_cmd_addr, 32'd0);
    wait_cmd(50);
    chk("second_addr", mem_cmd_addr, 32'd64);

    // Both requesting: starvation guard lets every fifth burst be the camera.
    do_reset();
    cam_req = 1'b1; lcd_req = 1'b1; xfer_len_cfg = 9;
    exp_we = 10'b10000_10000;
    got_we = 10'd0;
    for (int k = 0; k < 10; k++) begin
      wait_cmd(60);
      got_we[k] = mem_cmd_we;
      if (mem_cmd_we) cam_addr.push_back(int'(mem_cmd_addr));
    end
    chk("grant_order", got_we, exp_we);
    chk("cam_count", cam_addr.size(), 32'd2);
    if (cam_addr.size() == 2) begin
      chk("cam_addr0", cam_addr[0], 32'd0);
      chk("cam_addr1", cam_addr[1], 32'd64);
    end

    // Full frame of LCD bursts, then wrap.
    do_reset();
    cam_req = 1'b0; lcd_req = 1'b1; xfer_len_cfg = 0;
    for (int n = 1; n <= 4801; n++) begin
      wait_cmd(20);
      if (n == 1 || n == 2 || n == 4800 || n == 4801)
        chk("wrap_addr", mem_cmd_addr, ((n - 1) * BL) % FW);
    end

    // Frame restart during an LCD transfer takes effect on the next burst.
    do_reset();
    lcd_req = 1'b1; xfer_len_cfg = 5;
    for (int n = 0; n < 21; n++) wait_cmd(30);
    chk("pre_restart_addr", mem_cmd_addr, 32'd1280);
    cycle();
    cycle();
    lcd_frame_start = 1'b1;
    cycle();
    lcd_frame_start = 1'b0;
    chk("restart_grant_held", lcd_grant, 32'd1);
    wait_cmd(30);
    chk("restart_addr", mem_cmd_addr, BASE);

    // Command held stable while the controller stalls.
    do_reset();
    lcd_req = 1'b0; cam_req = 1'b1; mem_cmd_ready = 1'b0; xfer_len_cfg = 3;
    cycle();
    cam_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("stall_valid", mem_cmd_valid, 32'd1);
      chk("stall_we", mem_cmd_we, 32'd1);
      chk("stall_addr", mem_cmd_addr, 32'd0);
    end
    mem_cmd_ready = 1'b1;
    cycle();
    chk("stall_accept_grant", cam_grant, 32'd1);
    for (int i = 0; i < 8; i++) cycle();

    // Reset in the middle of a camera transfer.
    do_reset();
    cam_req = 1'b1; xfer_len_cfg = 8;
    wait_cmd(10);
    cycle();
    cycle();
    cycle();
    chk("pre_reset_grant", cam_grant, 32'd1);
    reset = 1'b1;
    cycle();
    chk("mid_reset_outs", {mem_cmd_valid, mem_cmd_we, mem_cmd_addr, cam_grant, lcd_grant}, 32'd0);
    reset = 1'b0;
    wait_cmd(10);
    chk("post_reset_addr", mem_cmd_addr, BASE);

    // Random traffic.
    rand_len = 1'b1; xfer_len_cfg = 6;
    for (int i = 0; i < 4000; i++) begin
      cam_req         = ($urandom_range(0, 3) != 0);
      lcd_req         = ($urandom_range(0, 2) != 0);
      mem_cmd_ready   = ($urandom_range(0, 3) != 0);
      cam_frame_start = ($urandom_range(0, 39) == 0);
      lcd_frame_start = ($urandom_range(0, 39) == 0);
      reset           = ($urandom_range(0, 599) == 0);
      cycle();
    end
    reset = 1'b0; cam_frame_start = 1'b0; lcd_frame_start = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_fb_arbiter.md
Name: lcd_fb_arbiter

Overview:
Schedules one shared frame-buffer memory port (SDRAM controller command interface) between two requesters: the camera write path and the LCD line-prefetch read path. LCD reads have priority so the 640x480 RGB565 scan-out FIFO never underruns; a starvation guard keeps camera bursts moving. The block owns both frame address counters, including wrap and per-frame restart, and issues one burst command at a time.

Parameters:
ADDR_W, 19, word address width of the memory port
BURST, 64, words per burst command (power of two)
FRAME_WORDS, 307200, words per frame (640*480); multiple of BURST
FB_BASE, 0, word address of the frame buffer start
MAX_LCD_RUN, 4, max consecutive LCD bursts granted while a camera request is pending

Ports:
clk  in  1  system/pixel-domain clock
reset  in  1  synchronous, active-high reset
cam_req  in  1  camera FIFO holds >= BURST words
cam_frame_start  in  1  one-cycle pulse at camera VSYNC; restart write address
lcd_req  in  1  LCD line FIFO level below watermark
lcd_frame_start  in  1  one-cycle pulse at LCD VSYNC; restart read address
mem_cmd_valid  out  1  burst command valid
mem_cmd_ready  in  1  memory controller accepts the command
mem_cmd_we  out  1  1 = write (camera), 0 = read (LCD)
mem_cmd_addr  out  ADDR_W  burst start word address
mem_burst_done  in  1  one-cycle pulse at completion of the last data word
cam_grant  out  1  high from command accept to burst done for a camera burst
lcd_grant  out  1  high from command accept to burst done for an LCD burst

Behaviour:
- Reset: all outputs 0; state IDLE; both address offsets 0; LCD run counter 0; pending-restart flags cleared. reset mid-burst aborts to IDLE immediately; the memory controller is reset by the same signal.
- States: IDLE, CAM_CMD, CAM_XFER, LCD_CMD, LCD_XFER. All outputs are registered.
- IDLE arbitration, evaluated each cycle:
  - lcd_req && !(cam_req && run==MAX_LCD_RUN) -> LCD_CMD
  - else cam_req -> CAM_CMD
  - else stay in IDLE.
- Latency: request seen in IDLE at cycle N -> mem_cmd_valid=1 at N+1.
- *_CMD: mem_cmd_valid=1; mem_cmd_we and mem_cmd_addr stay stable until mem_cmd_ready. On the accept cycle, advance to *_XFER; the matching grant goes 1 on the next cycle.
- *_XFER: grant held until mem_burst_done; then return to IDLE with the grant cleared the following cycle. There is at least one IDLE cycle between bursts.
- Requests are not re-sampled once a state is entered. Dropping a request during CMD or XFER does not cancel the burst.
- Run counter:
  - Increments on each accepted LCD command while cam_req=1, saturating at MAX_LCD_RUN.
  - Clears on any accepted camera command, or on an LCD accept with cam_req=0.
- Address:
  - mem_cmd_addr = FB_BASE + offset of the selected requester.
  - The offset advances by BURST at command accept; when it reaches FRAME_WORDS it wraps to 0.
  - Offset width is ADDR_W; FB_BASE+FRAME_WORDS must be <= 2^ADDR_W.
- Frame restart:
  - A frame_start pulse sets a pending flag for that requester.
  - The flag is applied (offset:=0) only when no burst of that requester is in CMD or XFER; otherwise it is applied on return to IDLE.
  - If the pulse coincides with that requester's command accept, the accept's advance is discarded and the offset becomes 0.
  - Pulses during reset are ignored.
- Simultaneous cam_req and lcd_req with run<MAX_LCD_RUN: LCD wins.

Decomposition:
- Shared package lcd_fb_pkg: state enumeration; constants FRAME_WORDS=640*480 and default BURST; the mem command we-encoding constants.
- One natural sub-module: fb_addr_gen (offset register, +BURST advance, wrap at FRAME_WORDS, pending-restart flag). Instantiate it once for the camera and once for the LCD.

Test Plan:
- Reset then lcd_req=1, mem_cmd_ready=1 -> mem_cmd_valid at cycle 1, we=0, addr=0; second burst addr=64 after burst_done.
- Both requests held, ready=1, burst_done 10 cycles after accept -> grant order LCD,LCD,LCD,LCD,CAM,LCD... with camera addresses 0,64,...
- LCD bursts continuously for 4800 bursts -> addresses 0..307136 step 64, then wrap to 0 on burst 4801.
- lcd_frame_start pulsed mid-LCD_XFER at offset 1280 -> that burst completes; next LCD command addr=0 (=FB_BASE).
- mem_cmd_ready held 0 for 20 cycles while cam_req deasserts -> mem_cmd_valid, we=1, addr unchanged all 20 cycles; accepted on cycle 21.
- reset asserted during CAM_XFER -> next cycle all outputs 0, offsets 0; first command after release addr=FB_BASE.
